layer_pipeline_scheduler: RTL and testbench

Parametrised successor to the fixed five-layer pipelined scheduler. Sequences an arbitrary-length chain of NUM_STAGES layers (conv/pool/fc), generating per-stage compute start pulses and per-boundary flat transfer indices/write strobes that move each stage's output memory into the next stage's input memory. Supports multi-frame streaming, with overlapped (pipelined) or one-stage-at-a-time (sequential) mode. Sits beside the layer instances at the top level, replacing the hand-wired scheduler.

---
 rtl/layer_pipeline_scheduler.sv | 173 +++++++++++++++++
 tb/tb_layer_pipeline_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_pipeline_scheduler.sv
// rtl/layer_pipeline_scheduler.sv - parametrised multi-stage layer scheduler with boundary transfers
// Launches each stage, moves stage k output memory into stage k+1 input memory, streams frames.
module layer_pipeline_scheduler #(
  parameter int NUM_STAGES = 5,
  parameter int IDX_W      = 16,
  parameter int FRAME_W    = 8,
  parameter logic [(NUM_STAGES-1)*IDX_W-1:0] XFER_LEN = {(NUM_STAGES-1){IDX_W'(1)}}
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [FRAME_W-1:0]              num_frames,
  input  logic                            mode,
  output logic [NUM_STAGES-1:0]           stage_start,
  input  logic [NUM_STAGES-1:0]           stage_done,
  output logic [(NUM_STAGES-1)*IDX_W-1:0] xfer_rd_index,
  output logic [(NUM_STAGES-1)*IDX_W-1:0] xfer_wr_index,
  output logic [NUM_STAGES-2:0]           xfer_wr_en,
  output logic                            busy,
  output logic                            done,
  output logic [FRAME_W-1:0]              frames_out,
  output logic                            err
);

  localparam int NB = NUM_STAGES - 1;

  typedef enum logic [1:0] {T_IDLE, T_RUN, T_DONE} top_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_XFER} stage_t;

  top_t               top;
  stage_t             st [NUM_STAGES];
  logic [FRAME_W-1:0] nf_q;
  logic [FRAME_W-1:0] launched;
  logic [FRAME_W-1:0] fo_inc;
  logic               seq_q;
  logic [IDX_W-1:0]   rd_q [NB];
  logic [IDX_W-1:0]   wr_q [NB];
  logic               rd_act [NB];
  logic [IDX_W-1:0]   xfer_last [NB];

  logic               any_active;
  logic [NB-1:0]      xfer_rdy;
  logic [NB-1:0]      xfer_go;
  logic               launch_rdy;
  logic               launch_go;
  logic               fin_done;

  for (genvar k = 0; k < NB; k++) begin : g_bnd
    assign xfer_last[k] = XFER_LEN[k*IDX_W +: IDX_W] - IDX_W'(1);
    assign xfer_rd_index[k*IDX_W +: IDX_W] = rd_q[k];
    assign xfer_wr_index[k*IDX_W +: IDX_W] = wr_q[k];
  end

  assign fin_done = (st[NUM_STAGES-1] == S_RUN) && stage_done[NUM_STAGES-1];
  assign fo_inc   = frames_out + 1'b1;

  // Sequential mode allows one new action only when nothing computes or transfers; the
  // highest ready boundary wins so the pipe drains before a new frame enters.
  always_comb begin
    any_active = 1'b0;
    for (int s = 0; s < NUM_STAGES; s++)
      if (st[s] == S_RUN || st[s] == S_XFER) any_active = 1'b1;
    for (int k = 0; k < NB; k++)
      xfer_rdy[k] = (st[k] == S_HOLD) && (st[k+1] == S_IDLE);
    launch_rdy = (top == T_RUN) && (st[0] == S_IDLE) && (launched < nf_q);
    xfer_go    = xfer_rdy;
    launch_go  = launch_rdy;
    if (seq_q) begin
      xfer_go   = '0;
      launch_go = 1'b0;
      if (!any_active) begin
        for (int k = 0; k < NB; k++) begin
          if (xfer_rdy[k]) begin
            xfer_go    = '0;
            xfer_go[k] = 1'b1;
          end
        end
        launch_go = launch_rdy && (xfer_rdy == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top         <= T_IDLE;
      nf_q        <= '0;
      seq_q       <= 1'b0;
      launched    <= '0;
      frames_out  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      stage_start <= '0;
      xfer_wr_en  <= '0;
      for (int s = 0; s < NUM_STAGES; s++) st[s] <= S_IDLE;
      for (int k = 0; k < NB; k++) begin
        rd_q[k]   <= '0;
        wr_q[k]   <= '0;
        rd_act[k] <= 1'b0;
      end
    end else begin
      stage_start <= '0;
      done        <= 1'b0;
      if (fin_done) frames_out <= fo_inc;

      case (top)
        T_IDLE: begin
          if (start) begin
            nf_q       <= num_frames;
            seq_q      <= mode;
            frames_out <= '0;
            busy       <= 1'b1;
            if (num_frames == '0) begin
              top      <= T_DONE;
              done     <= 1'b1;
              launched <= '0;
            end else begin
              // First launch happens on the accepting edge itself.
              top            <= T_RUN;
              launched       <= FRAME_W'(1);
              st[0]          <= S_RUN;
              stage_start[0] <= 1'b1;
            end
          end
        end
        T_RUN: begin
          if (fin_done && fo_inc == nf_q) begin
            top  <= T_DONE;
            done <= 1'b1;
          end
        end
        T_DONE: begin
          top  <= T_IDLE;
          busy <= 1'b0;
        end
        default: top <= T_IDLE;
      endcase

      if (launch_go) begin
        st[0]          <= S_RUN;
        stage_start[0] <= 1'b1;
        launched       <= launched + 1'b1;
      end

      for (int s = 0; s < NUM_STAGES; s++) begin
        if (stage_done[s] && st[s] != S_RUN) err <= 1'b1;
        if (stage_done[s] && st[s] == S_RUN)
          st[s] <= (s == NUM_STAGES - 1) ? S_IDLE : S_HOLD;
      end

      // Write side trails the read side by one cycle to cover output-memory read latency.
      for (int k = 0; k < NB; k++) begin
        if (xfer_go[k]) begin
          st[k]     <= S_XFER;
          rd_q[k]   <= '0;
          rd_act[k] <= 1'b1;
        end else if (st[k] == S_XFER) begin
          if (rd_act[k]) begin
            if (rd_q[k] == xfer_last[k]) rd_act[k] <= 1'b0;
            else                         rd_q[k]   <= rd_q[k] + 1'b1;
          end else if (xfer_wr_en[k]) begin
            st[k]            <= S_IDLE;
            st[k+1]          <= S_RUN;
            stage_start[k+1] <= 1'b1;
          end
        end
        xfer_wr_en[k] <= rd_act[k];
        wr_q[k]       <= rd_act[k] ? rd_q[k] : '0;
      end
    end
  end

endmodule

// File: tb/tb_layer_pipeline_scheduler.sv
// tb/tb_layer_pipeline_scheduler.sv - directed bench for layer_pipeline_scheduler
// Three stages, boundary lengths 4 and 2; history recorded per cycle relative to start.
module tb_layer_pipeline_scheduler;

  localparam int NS = 3;
  localparam int IW = 16;
  localparam int FW = 8;
  localparam int HN = 256;
  localparam logic [2*IW-1:0] XL = {16'd2, 16'd4};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [FW-1:0] num_frames = '0;
  logic [NS-1:0] stage_start;
  logic [NS-1:0] stage_done;
  logic [2*IW-1:0] xfer_rd_index;
  logic [2*IW-1:0] xfer_wr_index;
  logic [1:0]    xfer_wr_en;
  logic          busy;
  logic          done;
  logic [FW-1:0] frames_out;
  logic          err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int mi;

  logic [NS-1:0] ss_h  [HN];
  logic [1:0]    we_h  [HN];
  logic [IW-1:0] rd0_h [HN];
  logic [IW-1:0] rd1_h [HN];
  logic [IW-1:0] wr0_h [HN];
  logic [IW-1:0] wr1_h [HN];
  logic          done_h[HN];
  logic [FW-1:0] fo_h  [HN];

  int            dly [NS];
  int            cnt [NS];
  logic [NS-1:0] resp_done = '0;
  logic [NS-1:0] spur_done = '0;

  assign stage_done = resp_done | spur_done;

  layer_pipeline_scheduler #(
    .NUM_STAGES(NS), .IDX_W(IW), .FRAME_W(FW), .XFER_LEN(XL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_frames(num_frames), .mode(mode),
    .stage_start(stage_start), .stage_done(stage_done),
    .xfer_rd_index(xfer_rd_index), .xfer_wr_index(xfer_wr_index), .xfer_wr_en(xfer_wr_en),
    .busy(busy), .done(done), .frames_out(frames_out), .err(err)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Stage model: stage k raises stage_done dly[k] cycles after its stage_start.
  initial begin
    for (int k = 0; k < NS; k++) cnt[k] = 0;
    forever begin
      @(negedge clk);
      resp_done = '0;
      for (int k = 0; k < NS; k++) begin
        if (reset) cnt[k] = 0;
        else begin
          if (cnt[k] > 0) begin
            cnt[k] = cnt[k] - 1;
            if (cnt[k] == 0) resp_done[k] = 1'b1;
          end
          if (stage_start[k]) cnt[k] = dly[k];
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    #1;
    mi = cyc - t0;
    if (mi >= 0 && mi < HN) begin
      ss_h[mi]   = stage_start;
      we_h[mi]   = xfer_wr_en;
      rd0_h[mi]  = xfer_rd_index[15:0];
      rd1_h[mi]  = xfer_rd_index[31:16];
      wr0_h[mi]  = xfer_wr_index[15:0];
      wr1_h[mi]  = xfer_wr_index[31:16];
      done_h[mi] = done;
      fo_h[mi]   = frames_out;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int count_ss(input int k, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (ss_h[i][k] === 1'b1) n++;
    return n;
  endfunction

  task automatic launch(input int nf, input logic md, input int d0, input int d1, input int d2);
    dly[0] = d0;
    dly[1] = d1;
    dly[2] = d2;
    @(negedge clk);
    t0 = cyc;
    for (int i = 0; i < HN; i++) begin
      ss_h[i] = '0; we_h[i] = '0; rd0_h[i] = '0; rd1_h[i] = '0;
      wr0_h[i] = '0; wr1_h[i] = '0; done_h[i] = 1'b0; fo_h[i] = '0;
    end
    num_frames = FW'(nf);
    mode = md;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while (done !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ss"}, stage_start, 0);
    check({tag, "_we"}, xfer_wr_en, 0);
    check({tag, "_rd"}, xfer_rd_index, 0);
    check({tag, "_wr"}, xfer_wr_index, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_fo"}, frames_out, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic check_single_frame(input string tag);
    check({tag, "_ss0"}, ss_h[1], 3'b001);
    check({tag, "_ss1"}, ss_h[11], 3'b010);
    check({tag, "_ss2"}, ss_h[19], 3'b100);
    check({tag, "_done_early"}, done_h[22], 0);
    check({tag, "_done"}, done_h[23], 1);
    check({tag, "_fo"}, fo_h[23], 1);
  endtask

  int e0[3];
  int e1[3];
  int e2[3];
  int wcnt;

  initial begin
    dly = '{3, 3, 3};
    repeat (3) @(negedge clk);
    check_outputs_zero("rst");
    reset = 1'b0;
    @(negedge clk);

    // Single frame, pipelined: full transfer timing.
    launch(1, 1'b0, 3, 3, 3);
    wait_done(200);
    check_single_frame("s1");
    check("s1_we0_first_rd", we_h[6][0], 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("s1_rd0_%0d", i), rd0_h[6+i], i);
      check($sformatf("s1_wr0_%0d", i), wr0_h[7+i], i);
      check($sformatf("s1_we0_%0d", i), we_h[7+i][0], 1);
    end
    check("s1_we0_after", we_h[11][0], 0);
    check("s1_wr0_zero", wr0_h[11], 0);
    check("s1_rd0_hold", rd0_h[11], 3);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("s1_rd1_%0d", i), rd1_h[16+i], i);
      check($sformatf("s1_wr1_%0d", i), wr1_h[17+i], i);
      check($sformatf("s1_we1_%0d", i), we_h[17+i][1], 1);
    end
    check("s1_done_width", done_h[24], 0);
    check("s1_busy_end", busy, 0);

    // Three frames pipelined.
    launch(3, 1'b0, 3, 3, 3);
    wait_done(300);
    e0 = '{1, 12, 26};
    e1 = '{11, 25, 39};
    e2 = '{19, 33, 47};
    for (int i = 0; i < 3; i++) begin
      check($sformatf("s2_ss0_%0d", i), ss_h[e0[i]][0], 1);
      check($sformatf("s2_ss1_%0d", i), ss_h[e1[i]][1], 1);
      check($sformatf("s2_ss2_%0d", i), ss_h[e2[i]][2], 1);
      check($sformatf("s2_cnt_%0d", i), count_ss(i, 0, HN-1), 3);
    end
    check("s2_we0_wait", we_h[20][0], 0);
    check("s2_we0_f1", we_h[21][0], 1);
    check("s2_done", done_h[51], 1);
    check("s2_fo", fo_h[51], 3);

    // Back-pressure: slow stage 1 holds stage 0 in HOLD.
    launch(2, 1'b0, 3, 20, 3);
    wait_done(300);
    wcnt = 0;
    for (int i = 11; i <= 37; i++) if (we_h[i][0] === 1'b1) wcnt++;
    check("s3_no_we0", wcnt, 0);
    check("s3_we0_f1", we_h[38][0], 1);
    check("s3_ss1_f1", ss_h[42][1], 1);
    check("s3_ss2_f0", ss_h[36][2], 1);
    check("s3_done", done_h[71], 1);
    check("s3_fo", fo_h[71], 2);

    // Sequential mode, two frames.
    launch(2, 1'b1, 3, 3, 3);
    wait_done(300);
    e0 = '{1, 24, 0};
    e1 = '{11, 34, 0};
    e2 = '{19, 42, 0};
    for (int i = 0; i < 2; i++) begin
      check($sformatf("s4_ss0_%0d", i), ss_h[e0[i]][0], 1);
      check($sformatf("s4_ss1_%0d", i), ss_h[e1[i]][1], 1);
      check($sformatf("s4_ss2_%0d", i), ss_h[e2[i]][2], 1);
    end
    check("s4_cnt0", count_ss(0, 0, HN-1), 2);
    check("s4_we1_f0", we_h[17][1], 1);
    check("s4_done", done_h[46], 1);
    check("s4_fo", fo_h[46], 2);

    // Spurious completion while idle, then a clean run and a zero-frame run.
    @(negedge clk);
    spur_done = 3'b100;
    @(negedge clk);
    spur_done = '0;
    check("s5_err", err, 1);
    check("s5_busy", busy, 0);
    launch(1, 1'b0, 3, 3, 3);
    wait_done(200);
    check_single_frame("s5");
    check("s5_err_sticky", err, 1);
    launch(0, 1'b0, 3, 3, 3);
    wait_done(20);
    check("s6_done", done_h[1], 1);
    check("s6_nostart", count_ss(0, 0, 10) + count_ss(1, 0, 10) + count_ss(2, 0, 10), 0);
    check("s6_fo", fo_h[1], 0);

    // Reset mid-transfer, then a fresh run.
    launch(1, 1'b0, 3, 3, 3);
    repeat (7) @(negedge clk);
    check("s7_rd0_pre", xfer_rd_index[15:0], 2);
    check("s7_we0_pre", xfer_wr_en[0], 1);
    reset = 1'b1;
    #1;
    check_outputs_zero("s7");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    launch(1, 1'b0, 3, 3, 3);
    wait_done(200);
    check_single_frame("s8");
    check("s8_rd0_0", rd0_h[6], 0);
    check("s8_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
